hive_thrd_ctl: RTL and testbench

- Per-thread interrupt and clear request generator. It drives the irq and clt control inputs of the processor PC ring.
- Holds pending/enabled/in-service state for every thread and walks a thread-ID counter in lockstep with the ring.
- Asserts irq or clt for exactly one ring slot when the addressed thread is eligible.
- Initiator side of the PC-ring control interface: decides *when* a thread's PC is forced to IRQ_BASE or CLT_BASE.

---
 rtl/hive_thrd_ctl_pkg.sv | 27 ++
 rtl/hive_irq_edge.sv | 39 +++
 rtl/hive_thrd_ctl.sv | 110 +++++++++++
 tb/tb_hive_thrd_ctl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hive_thrd_ctl_pkg.sv
// Shared configuration and types for the thread-control slice of the hive core.
// hive_params fixes the ring geometry; hive_types builds the ID/vector types on top of it.
package hive_params;
  localparam int THREADS = 8;
  localparam int ID_W    = $clog2(THREADS);
endpackage

package hive_types;
  import hive_params::*;

  typedef logic [ID_W-1:0]    ID_T;
  typedef logic [THREADS-1:0] thrd_vec_t;

  // Outcome of the registered slot decision for the next ring thread.
  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_IRQ  = 2'd1,
    SLOT_CLT  = 2'd2
  } slot_e;

  function automatic thrd_vec_t id_mask(input ID_T id);
    thrd_vec_t m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/hive_irq_edge.sv
// Per-thread rising-edge detector on the external interrupt requests.
// HIVE_IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the detector for asynchronous req_i.
module hive_irq_edge
  import hive_params::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [THREADS-1:0] req_i,
  output logic [THREADS-1:0] rise_o
);

  logic [THREADS-1:0] req_s;
  logic [THREADS-1:0] req_q;

`ifdef HIVE_IRQ_SYNC_EN
  logic [THREADS-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      req_s  <= '0;
    end else begin
      sync_q <= req_i;
      req_s  <= sync_q;
    end
  end
`else
  assign req_s = req_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) req_q <= '0;
    else       req_q <= req_s;
  end

  assign rise_o = req_s & ~req_q;

endmodule

// File: rtl/hive_thrd_ctl.sv
// Per-thread irq/clt generator for the PC ring: tracks pending, enable, in-service and
// clear-pending state and pulses irq_o/clt_o in the ring slot of an eligible thread.
module hive_thrd_ctl
  import hive_params::*;
  import hive_types::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [THREADS-1:0] req_i,
  input  logic               en_wr_i,
  input  logic [THREADS-1:0] en_i,
  input  logic               clr_wr_i,
  input  logic [THREADS-1:0] clr_i,
  input  logic               irt_i,
  output logic [ID_W-1:0]    id_o,
  output logic               irq_o,
  output logic               clt_o,
  output logic [THREADS-1:0] en_o,
  output logic [THREADS-1:0] pnd_o,
  output logic [THREADS-1:0] ise_o
);

  ID_T       id_q;
  logic      irq_q;
  logic      clt_q;
  thrd_vec_t en_q;
  thrd_vec_t pnd_q;
  thrd_vec_t ise_q;
  thrd_vec_t clp_q;

  thrd_vec_t rise;
  ID_T       nxt_id;
  thrd_vec_t nxt_mask;
  thrd_vec_t irt_mask;
  slot_e     slot;
  thrd_vec_t pnd_d;
  thrd_vec_t ise_d;
  thrd_vec_t clp_d;

  hive_irq_edge u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .rise_o (rise)
  );

  // The decision is registered one slot early so irq_o/clt_o line up with id_o.
  assign nxt_id   = id_q + ID_T'(1);
  assign nxt_mask = id_mask(nxt_id);
  assign irt_mask = irt_i ? id_mask(id_q) : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot = SLOT_NONE;
    if (clp_q[nxt_id]) begin
      slot = SLOT_CLT;
    end else if (pnd_q[nxt_id] && en_q[nxt_id] && !ise_q[nxt_id]) begin
      slot = SLOT_IRQ;
    end
  end

  // Clears are applied before sets, so a new edge or clear write wins over consumption.
  always_comb begin
    pnd_d = pnd_q;
    ise_d = ise_q & ~irt_mask;
    clp_d = clp_q;
    unique case (slot)
      SLOT_CLT: begin
        clp_d = clp_d & ~nxt_mask;
        pnd_d = pnd_d & ~nxt_mask;
        ise_d = ise_d & ~nxt_mask;
      end
      SLOT_IRQ: begin
        pnd_d = pnd_d & ~nxt_mask;
        ise_d = ise_d | nxt_mask;
      end
      default: ;
    endcase
    pnd_d = pnd_d | rise;
    if (clr_wr_i) clp_d = clp_d | clr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q  <= '0;
      irq_q <= 1'b0;
      clt_q <= 1'b0;
      en_q  <= '0;
      pnd_q <= '0;
      ise_q <= '0;
      clp_q <= '0;
    end else begin
      id_q  <= nxt_id;
      irq_q <= (slot == SLOT_IRQ);
      clt_q <= (slot == SLOT_CLT);
      if (en_wr_i) en_q <= en_i;
      pnd_q <= pnd_d;
      ise_q <= ise_d;
      clp_q <= clp_d;
    end
  end

  assign id_o  = id_q;
  assign irq_o = irq_q;
  assign clt_o = clt_q;
  assign en_o  = en_q;
  assign pnd_o = pnd_q;
  assign ise_o = ise_q;

endmodule

// File: tb/tb_hive_thrd_ctl.sv
// Directed bench for hive_thrd_ctl: reset/ring walk, a table of per-clock vectors for the
// basic irq/irt flow, and hand sequences for masking, clear, set-beats-clear and latency.
module tb_hive_thrd_ctl;
  import hive_params::*;

`ifdef HIVE_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [THREADS-1:0] req_i;
  logic               en_wr_i;
  logic [THREADS-1:0] en_i;
  logic               clr_wr_i;
  logic [THREADS-1:0] clr_i;
  logic               irt_i;
  logic [ID_W-1:0]    id_o;
  logic               irq_o;
  logic               clt_o;
  logic [THREADS-1:0] en_o;
  logic [THREADS-1:0] pnd_o;
  logic [THREADS-1:0] ise_o;

  int total = 0;
  int bad   = 0;

  hive_thrd_ctl dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .en_wr_i  (en_wr_i),
    .en_i     (en_i),
    .clr_wr_i (clr_wr_i),
    .clr_i    (clr_i),
    .irt_i    (irt_i),
    .id_o     (id_o),
    .irq_o    (irq_o),
    .clt_o    (clt_o),
    .en_o     (en_o),
    .pnd_o    (pnd_o),
    .ise_o    (ise_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] req;
    logic       en_wr;
    logic [7:0] en;
    logic       irt;
    logic [2:0] id;
    logic       irq;
    logic [7:0] pnd;
    logic [7:0] ise;
  } row_t;

  row_t tbl [20];

  function automatic row_t mk(input logic [7:0] req, input logic en_wr, input logic [7:0] en,
                              input logic irt, input logic [2:0] id, input logic irq,
                              input logic [7:0] pnd, input logic [7:0] ise);
    row_t r;
    r.req = req; r.en_wr = en_wr; r.en = en; r.irt = irt;
    r.id = id; r.irq = irq; r.pnd = pnd; r.ise = ise;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_id(input logic [2:0] target);
    int n = 0;
    while (id_o !== target && n < 16) begin
      tick();
      n++;
    end
    if (id_o !== target) check("wait_id timeout", 32'(id_o), 32'(target));
  endtask

  task automatic check_idle_zero(input string name);
    check({name, " irq"}, 32'(irq_o), 0);
    check({name, " clt"}, 32'(clt_o), 0);
    check({name, " en"},  32'(en_o),  0);
    check({name, " pnd"}, 32'(pnd_o), 0);
    check({name, " ise"}, 32'(ise_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    req_i = '0; en_wr_i = 0; en_i = '0; clr_wr_i = 0; clr_i = '0; irt_i = 0;
    rst_i = 1;
    repeat (3) tick();
    check("reset id", 32'(id_o), 0);
    check_idle_zero("reset");

    // Ring walk out of reset: id wraps 7->0, no pulses, readbacks stay zero.
    rst_i = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("walk id", 32'(id_o), 32'((k + 1) % 8));
      check("walk irq", 32'(irq_o), 0);
      check("walk clt", 32'(clt_o), 0);
    end
    check("walk pnd", 32'(pnd_o), 0);
    check("walk ise", 32'(ise_o), 0);

`ifndef HIVE_IRQ_SYNC_EN
    // Each row: drive inputs in slot id, expect state after the next edge.
    tbl[0]  = mk(8'h00, 1, 8'hFF, 0, 3'd1, 0, 8'h00, 8'h00);
    tbl[1]  = mk(8'h08, 0, 8'h00, 0, 3'd2, 0, 8'h08, 8'h00);
    tbl[2]  = mk(8'h08, 0, 8'h00, 0, 3'd3, 1, 8'h00, 8'h08);
    tbl[3]  = mk(8'h08, 0, 8'h00, 0, 3'd4, 0, 8'h00, 8'h08);
    tbl[4]  = mk(8'h00, 0, 8'h00, 0, 3'd5, 0, 8'h00, 8'h08);
    tbl[5]  = mk(8'h08, 0, 8'h00, 0, 3'd6, 0, 8'h08, 8'h08);
    tbl[6]  = mk(8'h08, 0, 8'h00, 0, 3'd7, 0, 8'h08, 8'h08);
    tbl[7]  = mk(8'h08, 0, 8'h00, 0, 3'd0, 0, 8'h08, 8'h08);
    tbl[8]  = mk(8'h08, 0, 8'h00, 0, 3'd1, 0, 8'h08, 8'h08);
    tbl[9]  = mk(8'h08, 0, 8'h00, 0, 3'd2, 0, 8'h08, 8'h08);
    tbl[10] = mk(8'h08, 0, 8'h00, 0, 3'd3, 0, 8'h08, 8'h08);
    tbl[11] = mk(8'h08, 0, 8'h00, 1, 3'd4, 0, 8'h08, 8'h00);
    tbl[12] = mk(8'h08, 0, 8'h00, 0, 3'd5, 0, 8'h08, 8'h00);
    tbl[13] = mk(8'h08, 0, 8'h00, 0, 3'd6, 0, 8'h08, 8'h00);
    tbl[14] = mk(8'h08, 0, 8'h00, 0, 3'd7, 0, 8'h08, 8'h00);
    tbl[15] = mk(8'h08, 0, 8'h00, 0, 3'd0, 0, 8'h08, 8'h00);
    tbl[16] = mk(8'h08, 0, 8'h00, 0, 3'd1, 0, 8'h08, 8'h00);
    tbl[17] = mk(8'h08, 0, 8'h00, 0, 3'd2, 0, 8'h08, 8'h00);
    tbl[18] = mk(8'h08, 0, 8'h00, 0, 3'd3, 1, 8'h00, 8'h08);
    tbl[19] = mk(8'h08, 0, 8'h00, 1, 3'd4, 0, 8'h00, 8'h00);

    for (int r = 0; r < 20; r++) begin
      req_i = tbl[r].req; en_wr_i = tbl[r].en_wr; en_i = tbl[r].en; irt_i = tbl[r].irt;
      tick();
      check($sformatf("tbl[%0d] id", r),  32'(id_o),  32'(tbl[r].id));
      check($sformatf("tbl[%0d] irq", r), 32'(irq_o), 32'(tbl[r].irq));
      check($sformatf("tbl[%0d] clt", r), 32'(clt_o), 0);
      check($sformatf("tbl[%0d] pnd", r), 32'(pnd_o), 32'(tbl[r].pnd));
      check($sformatf("tbl[%0d] ise", r), 32'(ise_o), 32'(tbl[r].ise));
    end
    en_wr_i = 0; irt_i = 0;
    check("tbl en readback", 32'(en_o), 32'h00FF);

    // Disabled interrupt stays pending for 3 rotations, fires once enabled.
    req_i = '0; en_wr_i = 1; en_i = 8'h00;
    tick();
    en_wr_i = 0; req_i = 8'h20;
    tick();
    check("mask pnd set", 32'(pnd_o), 32'h20);
    for (int k = 0; k < 24; k++) begin
      tick();
      check("mask no irq", 32'(irq_o), 0);
      check("mask pnd held", 32'(pnd_o), 32'h20);
    end
    wait_id(3'd1);
    en_wr_i = 1; en_i = 8'h20;
    tick();
    en_wr_i = 0;
    check("mask en readback", 32'(en_o), 32'h20);
    n = 0;
    while (id_o !== 3'd5 && n < 8) begin
      check("mask irq early", 32'(irq_o), 0);
      tick();
      n++;
    end
    check("mask fire id", 32'(id_o), 5);
    check("mask fire irq", 32'(irq_o), 1);
    check("mask fire pnd", 32'(pnd_o), 0);
    check("mask fire ise", 32'(ise_o), 32'h20);
    irt_i = 1;
    tick();
    irt_i = 0;
    check("mask irt ise", 32'(ise_o), 0);

    // Clear request on a pending and in-service thread wins over irq.
    req_i = '0; en_wr_i = 1; en_i = 8'hFF;
    tick();
    en_wr_i = 0;
    wait_id(3'd0);
    req_i = 8'h04;
    tick();
    check("clr pnd2", 32'(pnd_o), 32'h04);
    tick();
    check("clr irq2", 32'(irq_o), 1);
    check("clr ise2", 32'(ise_o), 32'h04);
    req_i = 8'h00;
    tick();
    req_i = 8'h04;
    tick();
    check("clr id4", 32'(id_o), 4);
    check("clr repnd2", 32'(pnd_o), 32'h04);
    clr_wr_i = 1; clr_i = 8'h04;
    tick();
    clr_wr_i = 0; clr_i = '0;
    n = 0;
    while (id_o !== 3'd2 && n < 8) begin
      check("clr no pulse", 32'(irq_o | clt_o), 0);
      tick();
      n++;
    end
    check("clr clt", 32'(clt_o), 1);
    check("clr irq", 32'(irq_o), 0);
    check("clr pnd after", 32'(pnd_o), 0);
    check("clr ise after", 32'(ise_o), 0);
    tick();
    check("clr clt single", 32'(clt_o), 0);

    // New edge on thread 6 in the same clock its pending bit is consumed.
    req_i = '0;
    wait_id(3'd2);
    req_i = 8'h40;
    tick();
    check("sim pnd6", 32'(pnd_o), 32'h40);
    req_i = 8'h00;
    tick();
    tick();
    check("sim id5", 32'(id_o), 5);
    req_i = 8'h40;
    tick();
    check("sim irq6", 32'(irq_o), 1);
    check("sim pnd6 kept", 32'(pnd_o), 32'h40);
    check("sim ise6", 32'(ise_o), 32'h40);

    // Mid-operation reset drops in-service, pending and clear-pending state.
    clr_wr_i = 1; clr_i = 8'hFF;
    tick();
    clr_wr_i = 0; clr_i = '0; req_i = '0;
    rst_i = 1;
    tick();
    check("mrst id", 32'(id_o), 0);
    check_idle_zero("mrst");
    rst_i = 0;
    tick();
    check("mrst slot1 id", 32'(id_o), 1);
    check("mrst slot1 clt", 32'(clt_o), 0);
    tick();
    check("mrst slot2 clt", 32'(clt_o), 0);
    check("mrst slot2 irq", 32'(irq_o), 0);
`endif

    // req_i-to-pnd_o latency.
    req_i = 8'h01;
    n = 0;
    while (pnd_o[0] !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("latency clocks", 32'(n), 32'(LAT));
    req_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
